vga_plot_sink: RTL and testbench

- Responder end of the core's pixel-plot interface, the plot/x/y/color strobe the flow core drives.
- Accepts plot strobes into a small FIFO and converts (x,y) to linear framebuffer addresses in a 160x120, 15-bit colour buffer.
- Drains the FIFO to a framebuffer write port with a we/grant handshake.
- Performs a full-screen clear sweep on request; plots arriving during the sweep are queued.

---
 rtl/flow_vga_pkg.sv | 41 ++++
 rtl/vga_plot_sink_plot_fifo.sv | 66 ++++++
 rtl/vga_plot_sink.sv | 179 +++++++++++++++++
 tb/tb_vga_plot_sink.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_vga_pkg.sv
// Shared constants and types for the pixel-plot framebuffer path.
// The 160x120 framebuffer stores 15-bit {R5,G5,B5} colour at linear
// address y*160+x.
package flow_vga_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_PIXELS = 19200;

  localparam int FB_ADDR_W = 15;
  localparam int COLOR_W   = 15;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;

  // Sink state encoding
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  // Sized copies of the bounds so comparisons stay width-matched
  localparam logic [X_W-1:0]       FB_WIDTH_X  = 8'd160;
  localparam logic [Y_W-1:0]       FB_HEIGHT_Y = 7'd120;
  localparam logic [FB_ADDR_W-1:0] FB_PIXELS_A = 15'd19200;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]   color;
  } plot_entry_t;

  localparam int ENTRY_W = FB_ADDR_W + COLOR_W;

  // y*160 + x using shifts; maximum 19199 fits 15 bits without overflow
  function automatic logic [FB_ADDR_W-1:0] calc_addr(input logic [X_W-1:0] px,
                                                     input logic [Y_W-1:0] py);
    logic [FB_ADDR_W-1:0] yw;
    logic [FB_ADDR_W-1:0] xw;
    yw = {8'b0000_0000, py};
    xw = {7'b000_0000, px};
    return (yw << 3'd7) + (yw << 3'd5) + xw;
  endfunction

endpackage

// File: rtl/vga_plot_sink_plot_fifo.sv
// plot_fifo: synchronous FIFO holding queued plot entries.
// Head is presented combinationally; the consumer registers it.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against occupancy; pop frees a slot for a same-cycle push
  always_comb begin
    do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
    do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: responder for the plot/x/y/color strobe. Queues in-range
// plots as {linear address, colour}, drains them to a framebuffer write
// port (fb_we/fb_grant handshake) and runs full-screen clear sweeps.
// Plots arriving during a sweep wait in the FIFO and land afterwards.
// Optional build macro FLOW_PLOT_SINK_STATS_EN enables the saturating
// drop_count; without it drop_count is tied to zero.
module vga_plot_sink
  import flow_vga_pkg::*;
#(
  parameter int                 DEPTH       = 8,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = 15'h0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 plot,
  input  logic [X_W-1:0]       x,
  input  logic [Y_W-1:0]       y,
  input  logic [COLOR_W-1:0]   color,
  input  logic                 clear_req,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  input  logic                 fb_grant,
  output logic                 busy,
  output logic                 full,
  output logic                 overflow,
  output logic                 oob,
  output logic [7:0]           drop_count
);

  logic [0:0]           state_r;
  logic [FB_ADDR_W-1:0] sweep_r;      // next sweep address to load
  logic                 is_sweep_r;   // output register holds a sweep write
  logic                 fb_we_r;
  logic [FB_ADDR_W-1:0] fb_addr_r;
  logic [COLOR_W-1:0]   fb_data_r;
  logic                 overflow_r;
  logic                 oob_r;

  plot_entry_t          push_entry_s;
  plot_entry_t          head_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 in_range_s;
  logic                 transfer_s;
  logic                 load_free_s;
  logic                 sweep_done_s;
  logic                 run_mode_s;
  logic                 clear_load_s;
  logic                 drop_s;
  logic [FB_ADDR_W-1:0] sweep_addr_s;

  // Accept/drop decisions and output-register load selection
  always_comb begin
    in_range_s   = (x < FB_WIDTH_X) && (y < FB_HEIGHT_Y);
    transfer_s   = fb_we_r && fb_grant;
    load_free_s  = !fb_we_r || fb_grant;
    // Final sweep write leaving; a same-cycle clear_req restarts instead
    sweep_done_s = transfer_s && is_sweep_r && (state_r == CLEAR) &&
                   (sweep_r == FB_PIXELS_A) && !clear_req;
    // Once the sweep finishes the FIFO may refill the register that same edge
    run_mode_s   = (state_r == RUN) || sweep_done_s;
    pop_s        = run_mode_s && load_free_s && !fifo_empty_s;
    clear_load_s = !run_mode_s && load_free_s;
    if (clear_req) begin
      sweep_addr_s = {FB_ADDR_W{1'b0}};
    end else begin
      sweep_addr_s = sweep_r;
    end
    push_s             = plot && in_range_s && (!fifo_full_s || pop_s);
    drop_s             = plot && !push_s;
    push_entry_s.addr  = calc_addr(x, y);
    push_entry_s.color = color;
  end

  plot_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // RUN/CLEAR state and sweep address counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
      sweep_r <= {FB_ADDR_W{1'b0}};
    end else begin
      if (clear_req) begin
        state_r <= CLEAR;
      end else if (sweep_done_s) begin
        state_r <= RUN;
      end else begin
        state_r <= state_r;
      end
      if (clear_load_s) begin
        sweep_r <= sweep_addr_s + FB_ADDR_W'(1);
      end else if (clear_req) begin
        sweep_r <= {FB_ADDR_W{1'b0}};
      end else begin
        sweep_r <= sweep_r;
      end
    end
  end

  // Framebuffer write register: held while fb_we && !fb_grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_we_r    <= 1'b0;
      fb_addr_r  <= {FB_ADDR_W{1'b0}};
      fb_data_r  <= {COLOR_W{1'b0}};
      is_sweep_r <= 1'b0;
    end else if (pop_s) begin
      fb_we_r    <= 1'b1;
      fb_addr_r  <= head_s.addr;
      fb_data_r  <= head_s.color;
      is_sweep_r <= 1'b0;
    end else if (clear_load_s) begin
      fb_we_r    <= 1'b1;
      fb_addr_r  <= sweep_addr_s;
      fb_data_r  <= CLEAR_COLOR;
      is_sweep_r <= 1'b1;
    end else if (transfer_s) begin
      fb_we_r    <= 1'b0;
      is_sweep_r <= 1'b0;
    end else begin
      fb_we_r    <= fb_we_r;
      is_sweep_r <= is_sweep_r;
    end
  end

  // Sticky drop flags, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
      oob_r      <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (drop_s & in_range_s);
      oob_r      <= oob_r | (drop_s & !in_range_s);
    end
  end

`ifdef FLOW_PLOT_SINK_STATS_EN
  logic [7:0] drop_count_r;

  // Saturating count of every dropped plot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count_r <= 8'h00;
    end else if (drop_s && (drop_count_r != 8'hFF)) begin
      drop_count_r <= drop_count_r + 8'd1;
    end else begin
      drop_count_r <= drop_count_r;
    end
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = 8'h00;
`endif

  assign fb_we    = fb_we_r;
  assign fb_addr  = fb_addr_r;
  assign fb_data  = fb_data_r;
  assign overflow = overflow_r;
  assign oob      = oob_r;
  assign full     = fifo_full_s;
  assign busy     = (state_r == CLEAR) || !fifo_empty_s || fb_we_r;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Self-checking bench for vga_plot_sink: directed vector table, multi-cycle
// corner sequences (overflow, clear sweep, sweep restart, reset mid-hold)
// and a randomized phase scored against an in-order write queue.
module tb_vga_plot_sink;

  localparam int          DEPTH = 8;
  localparam logic [14:0] CLR   = 15'h2A5A;

  logic        clock = 1'b0;
  logic        reset;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [14:0] color;
  logic        clear_req;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [14:0] fb_data;
  logic        fb_grant;
  logic        busy;
  logic        full;
  logic        overflow;
  logic        oob;
  logic [7:0]  drop_count;

  typedef struct {
    logic [14:0] addr;
    logic [14:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] c;
    int          exp_addr;
    bit          exp_drop;
  } vec_t;

  wr_t  obs_q[$];
  wr_t  exp_q[$];
  vec_t vecs[9];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_drops = 0;
  bit exp_oob   = 1'b0;
  bit exp_ovf   = 1'b0;

  always #5 clock = ~clock;

  vga_plot_sink #(
    .DEPTH       (DEPTH),
    .CLEAR_COLOR (CLR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .color      (color),
    .clear_req  (clear_req),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_grant   (fb_grant),
    .busy       (busy),
    .full       (full),
    .overflow   (overflow),
    .oob        (oob),
    .drop_count (drop_count)
  );

  // Record every write that will complete at the coming rising edge
  always @(negedge clock) begin
    if (!reset && fb_we && fb_grant) obs_q.push_back('{fb_addr, fb_data});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_dc();
`ifdef FLOW_PLOT_SINK_STATS_EN
    return (exp_drops > 255) ? 255 : exp_drops;
`else
    return 0;
`endif
  endfunction

  task automatic wait_idle(input int max_cycles, input string name);
    int n;
    n = 0;
    while ((busy || fb_we) && (n < max_cycles)) begin
      tick();
      n++;
    end
    check({name, "_idle"}, int'(busy), 0);
  endtask

  // Compare observed writes in order against the expected queue
  task automatic drain_compare(input string name);
    wr_t o;
    wr_t e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        check({name, "_unexpected_write"}, int'(o.addr), -1);
      end else begin
        e = exp_q.pop_front();
        check({name, "_addr"}, int'(o.addr), int'(e.addr));
        check({name, "_data"}, int'(o.data), int'(e.data));
      end
    end
  endtask

  initial begin
    int  bad;
    int  found;
    int  xx;
    int  yy;
    wr_t last;

    vecs[0] = '{8'd5,   7'd2,   15'h7C00, 325,   1'b0};
    vecs[1] = '{8'd0,   7'd0,   15'h001F, 0,     1'b0};
    vecs[2] = '{8'd1,   7'd0,   15'h03E0, 1,     1'b0};
    vecs[3] = '{8'd0,   7'd1,   15'h1234, 160,   1'b0};
    vecs[4] = '{8'd100, 7'd50,  15'h4321, 8100,  1'b0};
    vecs[5] = '{8'd159, 7'd119, 15'h7FFF, 19199, 1'b0};
    vecs[6] = '{8'd160, 7'd0,   15'h0001, 0,     1'b1};
    vecs[7] = '{8'd0,   7'd120, 15'h0002, 0,     1'b1};
    vecs[8] = '{8'd255, 7'd127, 15'h0003, 0,     1'b1};

    reset = 1'b1; plot = 1'b0; clear_req = 1'b0; fb_grant = 1'b1;
    x = 8'd0; y = 7'd0; color = 15'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_fb_we",    int'(fb_we),      0);
    check("rst_fb_addr",  int'(fb_addr),    0);
    check("rst_fb_data",  int'(fb_data),    0);
    check("rst_busy",     int'(busy),       0);
    check("rst_full",     int'(full),       0);
    check("rst_overflow", int'(overflow),   0);
    check("rst_oob",      int'(oob),        0);
    check("rst_drop",     int'(drop_count), 0);
    reset = 1'b0;
    tick();

    // Directed vectors, grant held high
    for (int i = 0; i < 9; i++) begin
      plot = 1'b1; x = vecs[i].x; y = vecs[i].y; color = vecs[i].c;
      tick();
      plot = 1'b0;
      tick();
      if (vecs[i].exp_drop) begin
        exp_drops++; exp_oob = 1'b1;
        check("vec_oob_no_we", int'(fb_we), 0);
        check("vec_oob_flag",  int'(oob),   1);
      end else begin
        check("vec_we",   int'(fb_we),   1);
        check("vec_addr", int'(fb_addr), vecs[i].exp_addr);
        check("vec_data", int'(fb_data), int'(vecs[i].c));
        tick();
        check("vec_busy_after", int'(busy), 0);
      end
    end
    check("vec_oob_sticky", int'(oob),        int'(exp_oob));
    check("vec_overflow",   int'(overflow),   0);
    check("vec_drop_count", int'(drop_count), exp_dc());
    obs_q.delete();

    // Overflow: grant low, one held write plus DEPTH queued, next plot dropped
    fb_grant = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      plot = 1'b1; x = 8'(i); y = 7'd3; color = 15'(256 + i);
      tick();
    end
    plot = 1'b0;
    exp_drops++; exp_ovf = 1'b1;
    check("ovf_flag",  int'(overflow),   1);
    check("ovf_full",  int'(full),       1);
    check("ovf_we",    int'(fb_we),      1);
    check("ovf_drops", int'(drop_count), exp_dc());
    repeat (3) tick();
    check("ovf_hold_addr", int'(fb_addr), 480);
    check("ovf_hold_data", int'(fb_data), 256);
    // Push into a full FIFO succeeds when the register drains the same cycle
    fb_grant = 1'b1; plot = 1'b1; x = 8'd20; y = 7'd3; color = 15'h0777;
    tick();
    plot = 1'b0;
    check("ovf_pushpop_full",  int'(full),       1);
    check("ovf_pushpop_drops", int'(drop_count), exp_dc());
    wait_idle(100, "ovf");
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back('{15'(480 + i), 15'(256 + i)});
    exp_q.push_back('{15'd500, 15'h0777});
    drain_compare("ovf");
    check("ovf_missing", exp_q.size(), 0);
    exp_q.delete();

    // Full clear sweep with a plot queued mid-sweep
    obs_q.delete();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (300) tick();
    plot = 1'b1; x = 8'd1; y = 7'd0; color = 15'h001F;
    tick();
    plot = 1'b0;
    check("sweep_busy", int'(busy), 1);
    wait_idle(20000, "sweep");
    check("sweep_count", obs_q.size(), 19201);
    bad = 0;
    for (int i = 0; i < 19200 && i < obs_q.size(); i++)
      if (int'(obs_q[i].addr) != i || obs_q[i].data != CLR) bad++;
    check("sweep_content", bad, 0);
    if (obs_q.size() > 0) begin
      last = obs_q[obs_q.size() - 1];
      check("sweep_plot_addr", int'(last.addr), 1);
      check("sweep_plot_data", int'(last.data), int'(15'h001F));
    end

    // Restart at 500, with a plot arriving together with the first clear_req
    obs_q.delete();
    plot = 1'b1; x = 8'd7; y = 7'd1; color = 15'h5555; clear_req = 1'b1;
    tick();
    plot = 1'b0; clear_req = 1'b0;
    found = 0;
    for (int n = 0; n < 1000 && found == 0; n++) begin
      if (fb_we && fb_addr == 15'd500) begin
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        found = 1;
      end else begin
        tick();
      end
    end
    check("restart_seen", found, 1);
    check("restart_addr0", int'(fb_addr), 0);
    wait_idle(21000, "restart");
    check("restart_count", obs_q.size(), 501 + 19200 + 1);
    if (obs_q.size() == 19702) begin
      check("restart_500",  int'(obs_q[500].addr),   500);
      check("restart_0",    int'(obs_q[501].addr),   0);
      check("restart_last", int'(obs_q[19700].addr), 19199);
      check("restart_plot", int'(obs_q[19701].addr), 167);
      check("restart_pdat", int'(obs_q[19701].data), int'(15'h5555));
    end

    // Reset while a write is held and three entries are queued
    obs_q.delete();
    fb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      plot = 1'b1; x = 8'(10 + i); y = 7'd0; color = 15'(i);
      tick();
    end
    plot = 1'b0;
    check("hold_we", int'(fb_we), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_we",       int'(fb_we),    0);
    check("arst_busy",     int'(busy),     0);
    check("arst_overflow", int'(overflow), 0);
    exp_drops = 0; exp_oob = 1'b0; exp_ovf = 1'b0;
    tick();
    reset = 1'b0; fb_grant = 1'b1;
    obs_q.delete();
    repeat (20) tick();
    check("arst_no_writes", obs_q.size(), 0);
    check("arst_busy_after", int'(busy), 0);

    // Randomized plots against the in-order write model
    for (int c = 0; c < 800; c++) begin
      drain_compare("rnd");
      fb_grant = ($urandom_range(0, 9) < 7);
      plot = 1'b0;
      if ($urandom_range(0, 9) < 5) begin
        if ($urandom_range(0, 9) < 2) begin
          if ($urandom_range(0, 1) == 0) begin
            x = 8'($urandom_range(160, 255)); y = 7'($urandom_range(0, 127));
          end else begin
            x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(120, 127));
          end
          color = 15'($urandom);
          plot = 1'b1; exp_oob = 1'b1; exp_drops++;
        end else if (exp_q.size() < DEPTH) begin
          xx = int'($urandom_range(0, 159)); yy = int'($urandom_range(0, 119));
          x = 8'(xx); y = 7'(yy); color = 15'($urandom);
          plot = 1'b1;
          exp_q.push_back('{15'(yy * 160 + xx), color});
        end
      end
      tick();
    end
    plot = 1'b0; fb_grant = 1'b1;
    wait_idle(200, "rnd");
    drain_compare("rnd_tail");
    check("rnd_left",     exp_q.size(),      0);
    check("rnd_oob",      int'(oob),         int'(exp_oob));
    check("rnd_overflow", int'(overflow),    int'(exp_ovf));
    check("rnd_drops",    int'(drop_count),  exp_dc());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
